azadi_wb_ctrl: RTL and testbench
================================

# azadi_wb_ctrl

Wishbone-slave control block between the Caravel management Wishbone port and the Azadi SoC core. It provides a register-programmable UART `clks_per_bit` value and a stretched, software-triggerable SoC reset (`soc_rst_ni`). It also synchronises and debounces the raw programming-button pad input before it reaches the SoC `prog` pin, with an optional software override. It occupies one 256-byte window of the user Wishbone space.

## Interface
Parameters:
- `BASE_ADDR`, 32'h3000_0000, window base; only bits [31:8] are compared.
- `RST_CYCLES`, 16, SoC reset hold length in cycles; must be ≥2.
- `DEBOUNCE`, 1024, consecutive stable cycles required to accept a new `prog` level.
- `CPB_RESET`, 16'd868, reset value of `clks_per_bit`.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1  Wishbone strobe, cycle and write-enable.
- `wbs_sel_i`  in  4  byte enables.
- `wbs_adr_i`, `wbs_dat_i`  in  32  address and write data.
- `wbs_ack_o`  out  1  acknowledge; reset 0.
- `wbs_dat_o`  out  32  read data; reset 0.
- `prog_pad_i`  in  1  raw, asynchronous button pad.
- `prog_o`  out  1  to SoC `prog`; reset 0.
- `soc_rst_ni`  out  1  active-low SoC reset; reset 0.
- `clks_per_bit`  out  16  to SoC UART; reset `CPB_RESET`.

## Operation
Register map (offsets; unmapped offsets read 0 and ignore writes):
- **0x00 CTRL**
  - bit0 `RST_REQ`: write-1 triggers a SoC reset; self-clearing, always reads 0.
  - bit1 `PROG_OVR`: software override enable.
  - bit2 `PROG_VAL`: override value.
- **0x04 CPB**: [15:0] `clks_per_bit`; bits [31:16] read 0.
- **0x08 STATUS** (read-only):
  - bit0: 1 while in HOLD.
  - bit1: debounced pad level.
  - bit2: raw synchronised pad level.
- **0x0C SCRATCH**: 32-bit read/write.

Writes honour `wbs_sel_i` per byte. `RST_REQ` acts only when `wbs_sel_i[0]` is set.

Reset sequencer, states HOLD and RUN:
- `wb_rst_i` forces HOLD with counter 0.
- In HOLD the counter increments every cycle. At `RST_CYCLES-1` the state moves to RUN.
- `soc_rst_ni` is registered and equals (state==RUN).
- An `RST_REQ` write in RUN enters HOLD with counter 0. An `RST_REQ` write in HOLD restarts the counter at 0.
- Registers (CPB, CTRL, SCRATCH) are not cleared by a software reset.

Prog path:
- 2-flop synchroniser followed by the debouncer.
- Debounce counter clears whenever synchronised == debounced. Otherwise it increments.
- When the counter reaches `DEBOUNCE-1`, debounced takes the synchronised value and the counter clears.
- `prog_o` = `PROG_OVR ? PROG_VAL : debounced`, registered.

## Timing
- **Request:** accepted in cycle N when `stb & cyc & ~ack` and `adr[31:8]==BASE_ADDR[31:8]`.
- **Acknowledge:** `wbs_ack_o`=1 in cycle N+1 only, then 0. Back-to-back requests therefore ack at most every other cycle.
- **Outside the window:** no ack is generated and `wbs_dat_o` stays 0.
- **Reads:** `wbs_dat_o` is valid in the ack cycle and is 0 in all other cycles.
- **Writes:** register contents update at the N+1 edge. `clks_per_bit` changes in cycle N+1. The CTRL override reaches `prog_o` in N+2.
- **Software reset latency:** an `RST_REQ` write accepted at N drives `soc_rst_ni`=0 from N+2. It stays 0 for exactly `RST_CYCLES` cycles.
- **Power-on release:** after `wb_rst_i` deasserts, `soc_rst_ni` rises on the `RST_CYCLES`-th edge.
- **Prog latency:** a pad edge that stays stable reaches `prog_o` after 2 (sync) + `DEBOUNCE` + 1 cycles.
- **`wb_rst_i` mid-transaction:** ack is dropped immediately and all outputs return to their reset values asynchronously.

## Structure
- **Package `azadi_wb_ctrl_pkg`:**
  - register offset localparams (`CTRL_OFF`, `CPB_OFF`, `STATUS_OFF`, `SCRATCH_OFF`);
  - CTRL bit-index constants;
  - `rst_state_e` enum {`HOLD`, `RUN`}.
- **Sub-module `azadi_sync_debounce`:**
  - parameter `DEBOUNCE`;
  - ports: `wb_clk_i`, `wb_rst_i`, `d_i`, `sync_o`, `q_o`;
  - contains the synchroniser and debounce counter; reused for future pad inputs.
- **Top level:** Wishbone decode, register file and reset sequencer.

## Test plan
- **Reset release:** assert `wb_rst_i` for 3 cycles then release, with `RST_CYCLES`=16. Required: `soc_rst_ni`=0 for 16 edges then 1; `clks_per_bit`=868; `prog_o`=0; `wbs_ack_o`=0.
- **CPB access:**
  - Write 0x04=0x0000_1B2 with sel=4'b0011: `clks_per_bit`=0x01B2 one cycle after the accept cycle; ack is a single cycle.
  - Read back: 0x000001B2.
  - Write with sel=4'b0001 of 0xFF: reads back 0x01FF.
- **Software reset:** in RUN, write CTRL=1. Required: `soc_rst_ni` low from N+2 for 16 cycles. A second `RST_REQ` written 5 cycles in extends the low time to 5+16 cycles. CPB and SCRATCH keep their values.
- **Debounce** (`DEBOUNCE`=8):
  - A pad glitch high for 5 cycles leaves `prog_o` at 0.
  - Pad held high: `prog_o`=1 after 11 cycles.
  - STATUS reads 0b110.
- **Override:** write CTRL=0b110 with the pad at 0. Required: `prog_o`=1 at N+2. Writing CTRL=0 restores the debounced value.
- **Decode:**
  - Access 0x3000_0100 (outside the window): no ack for 10 cycles.
  - Read 0x3000_0020 (unmapped in window): ack with data 0.
  - Continuous `stb`: ack pulses alternate 1/0.

Source files
------------

// File: rtl/azadi_wb_ctrl_pkg.sv
// rtl/azadi_wb_ctrl_pkg.sv - register map, CTRL bit indices and reset sequencer states
// Shared by the Wishbone control block and its helpers.
package azadi_wb_ctrl_pkg;

    localparam logic [7:0] CTRL_OFF    = 8'h00;
    localparam logic [7:0] CPB_OFF     = 8'h04;
    localparam logic [7:0] STATUS_OFF  = 8'h08;
    localparam logic [7:0] SCRATCH_OFF = 8'h0C;

    localparam int CTRL_RST_REQ  = 0;
    localparam int CTRL_PROG_OVR = 1;
    localparam int CTRL_PROG_VAL = 2;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } rst_state_e;

    // Byte-lane merge of write data into an existing 32-bit register value.
    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  sel);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/azadi_sync_debounce.sv
// rtl/azadi_sync_debounce.sv - two-flop synchroniser followed by a stability debouncer
// A new level is accepted only after DEBOUNCE consecutive cycles of disagreement.
module azadi_sync_debounce #(
    parameter int DEBOUNCE = 1024
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic d_i,
    output logic sync_o,
    output logic q_o
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic          meta_q, meta_d;
    logic          sync_q, sync_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
        deb_d  = deb_q;
        cnt_d  = '0;
        if (sync_q != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sync_o = sync_q;
    assign q_o    = deb_q;

endmodule

// File: rtl/azadi_wb_ctrl.sv
// rtl/azadi_wb_ctrl.sv - Wishbone slave with CPB/CTRL/STATUS/SCRATCH registers
// Drives the stretched SoC reset, UART clks_per_bit and the debounced prog pin.
module azadi_wb_ctrl
    import azadi_wb_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          RST_CYCLES = 16,
    parameter int          DEBOUNCE   = 1024,
    parameter logic [15:0] CPB_RESET  = 16'd868
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        prog_pad_i,
    output logic        prog_o,
    output logic        soc_rst_ni,
    output logic [15:0] clks_per_bit
);

    localparam int RCW = $clog2(RST_CYCLES);
    localparam logic [RCW-1:0] RC_MAX = RCW'(RST_CYCLES - 1);

    logic            ack_q, ack_d;
    logic [31:0]     dat_q, dat_d;
    logic [15:0]     cpb_q, cpb_d;
    logic            ovr_q, ovr_d;
    logic            val_q, val_d;
    logic [31:0]     scratch_q, scratch_d;
    logic            rst_req_q, rst_req_d;
    rst_state_e      state_q, state_d;
    logic [RCW-1:0]  rcnt_q, rcnt_d;
    logic            soc_q, soc_d;
    logic            prog_q, prog_d;

    logic            prog_sync, prog_deb;
    logic            req, wr, rd;
    logic [7:0]      off;
    logic [31:0]     rdata;

    azadi_sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_prog_db (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .d_i      (prog_pad_i),
        .sync_o   (prog_sync),
        .q_o      (prog_deb)
    );

    // A request is taken only while no ack is outstanding, so acks never stack.
    assign req = wbs_stb_i & wbs_cyc_i & ~ack_q & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr  = req & wbs_we_i;
    assign rd  = req & ~wbs_we_i;
    assign off = wbs_adr_i[7:0];

    always_comb begin
        rdata = '0;
        case (off)
            CTRL_OFF:    rdata = {29'b0, val_q, ovr_q, 1'b0};
            CPB_OFF:     rdata = {16'b0, cpb_q};
            STATUS_OFF:  rdata = {29'b0, prog_sync, prog_deb, (state_q == HOLD)};
            SCRATCH_OFF: rdata = scratch_q;
            default:     rdata = '0;
        endcase
    end

    always_comb begin
        ack_d     = req;
        dat_d     = rd ? rdata : '0;
        cpb_d     = cpb_q;
        ovr_d     = ovr_q;
        val_d     = val_q;
        scratch_d = scratch_q;
        rst_req_d = 1'b0;
        if (wr) begin
            case (off)
                CTRL_OFF: begin
                    if (wbs_sel_i[0]) begin
                        rst_req_d = wbs_dat_i[CTRL_RST_REQ];
                        ovr_d     = wbs_dat_i[CTRL_PROG_OVR];
                        val_d     = wbs_dat_i[CTRL_PROG_VAL];
                    end
                end
                CPB_OFF: begin
                    if (wbs_sel_i[0]) cpb_d[7:0]  = wbs_dat_i[7:0];
                    if (wbs_sel_i[1]) cpb_d[15:8] = wbs_dat_i[15:8];
                end
                SCRATCH_OFF: scratch_d = apply_sel(scratch_q, wbs_dat_i, wbs_sel_i);
                default: ;
            endcase
        end
    end

    // The request is staged one cycle so the SoC reset falls two cycles after accept.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        if (rst_req_q) begin
            state_d = HOLD;
            rcnt_d  = '0;
        end else if (state_q == HOLD) begin
            if (rcnt_q == RC_MAX) begin
                state_d = RUN;
                rcnt_d  = '0;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
        soc_d  = (state_d == RUN);
        prog_d = ovr_q ? val_q : prog_deb;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            cpb_q     <= CPB_RESET;
            ovr_q     <= 1'b0;
            val_q     <= 1'b0;
            scratch_q <= '0;
            rst_req_q <= 1'b0;
            state_q   <= HOLD;
            rcnt_q    <= '0;
            soc_q     <= 1'b0;
            prog_q    <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            cpb_q     <= cpb_d;
            ovr_q     <= ovr_d;
            val_q     <= val_d;
            scratch_q <= scratch_d;
            rst_req_q <= rst_req_d;
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            soc_q     <= soc_d;
            prog_q    <= prog_d;
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign clks_per_bit = cpb_q;
    assign soc_rst_ni   = soc_q;
    assign prog_o       = prog_q;

endmodule

// File: tb/tb_azadi_wb_ctrl.sv
// tb/tb_azadi_wb_ctrl.sv - self-checking bench for azadi_wb_ctrl
// Directed steps plus random register traffic against a register-map model.
module tb_azadi_wb_ctrl;

    localparam int          RST_CYCLES = 16;
    localparam int          DEBOUNCE   = 8;
    localparam logic [31:0] BASE       = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        pad;
    logic        prog_o;
    logic        soc_rst_ni;
    logic [15:0] cpb;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_scratch;
    logic [15:0] m_cpb;
    logic        m_ovr, m_val, m_deb;

    always #5 clk = ~clk;

    azadi_wb_ctrl #(
        .BASE_ADDR (BASE),
        .RST_CYCLES(RST_CYCLES),
        .DEBOUNCE  (DEBOUNCE),
        .CPB_RESET (16'd868)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .prog_pad_i  (pad),
        .prog_o      (prog_o),
        .soc_rst_ni  (soc_rst_ni),
        .clks_per_bit(cpb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] off);
        case (off)
            8'h00:   return {29'b0, m_val, m_ovr, 1'b0};
            8'h04:   return {16'b0, m_cpb};
            8'h08:   return {29'b0, m_deb, m_deb, 1'b0};
            8'h0C:   return m_scratch;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        case (off)
            8'h00: if (s[0]) begin m_ovr = d[1]; m_val = d[2]; end
            8'h04: begin
                if (s[0]) m_cpb[7:0]  = d[7:0];
                if (s[1]) m_cpb[15:8] = d[15:8];
            end
            8'h0C: for (int b = 0; b < 4; b++) if (s[b]) m_scratch[b*8 +: 8] = d[b*8 +: 8];
            default: ;
        endcase
    endfunction

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        m_write(a[7:0], d, s);
        chk("wr_ack", {31'b0, ack}, 32'h1);
        chk("wr_dat_zero", rdat, 32'h0);
        chk("wr_cpb_out", {16'b0, cpb}, {16'b0, m_cpb});
        @(negedge clk);
        chk("wr_ack_drop", {31'b0, ack}, 32'h0);
        chk("wr_prog", {31'b0, prog_o}, {31'b0, (m_ovr ? m_val : m_deb)});
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0;
        chk("rd_ack", {31'b0, ack}, 32'h1);
        d = rdat;
        @(negedge clk);
        chk("rd_ack_drop", {31'b0, ack}, 32'h0);
        chk("rd_dat_idle", rdat, 32'h0);
    endtask

    // Software reset via CTRL; a second request may be issued 'second' cycles later.
    task automatic sw_reset(input int second);
        int  lowcnt;
        bit  exp_low;
        lowcnt = 0;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            exp_low = (c >= 2 && c <= RST_CYCLES + 1) ||
                      (second >= 0 && c >= second + 2 && c <= second + RST_CYCLES + 1);
            chk($sformatf("swrst_c%0d", c), {31'b0, soc_rst_ni}, {31'b0, ~exp_low});
            if (soc_rst_ni === 1'b0) lowcnt++;
            if (c == 0 || c == second) begin
                stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE; wdat = 32'h1; sel = 4'hF;
                m_write(8'h00, 32'h1, 4'hF);
            end else begin
                stb = 1'b0; cyc = 1'b0; we = 1'b0;
            end
        end
        chk("swrst_low_len", lowcnt, (second < 0) ? RST_CYCLES : second + RST_CYCLES);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  offs [7];
        logic [7:0]  off;
        logic [3:0]  s;
        logic [31:0] r;
        int          rise, first;
        bit          seen;

        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h3C};
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; wdat = 32'h0; pad = 1'b0;
        m_scratch = 32'h0; m_cpb = 16'd868; m_ovr = 1'b0; m_val = 1'b0; m_deb = 1'b0;

        // Power-on reset and release
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_soc", {31'b0, soc_rst_ni}, 32'h0);
        chk("rst_cpb", {16'b0, cpb}, 32'd868);
        chk("rst_prog", {31'b0, prog_o}, 32'h0);
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_dat", rdat, 32'h0);
        rst = 1'b0;
        rise = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (soc_rst_ni === 1'b1) begin
                rise = k;
                break;
            end
        end
        chk("por_release_edge", rise, RST_CYCLES);

        // CPB access
        wb_write(BASE + 32'h4, 32'h0000_01B2, 4'b0011);
        wb_read(BASE + 32'h4, d);
        chk("cpb_rd1", d, 32'h0000_01B2);
        wb_write(BASE + 32'h4, 32'h0000_00FF, 4'b0001);
        wb_read(BASE + 32'h4, d);
        chk("cpb_rd2", d, 32'h0000_01FF);

        // Random register traffic
        for (int i = 0; i < 40; i++) begin
            off = offs[$urandom_range(0, 6)];
            s   = 4'($urandom);
            r   = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                if (off == 8'h00) r[0] = 1'b0;
                wb_write(BASE | {24'b0, off}, r, s);
            end else begin
                wb_read(BASE | {24'b0, off}, d);
                chk($sformatf("rand_rd_%0h", off), d, m_read(off));
            end
        end
        wb_write(BASE, 32'h0, 4'hF);

        // Software reset, single and extended
        wb_write(BASE + 32'hC, 32'hDEAD_BEEF, 4'hF);
        sw_reset(-1);
        sw_reset(5);
        wb_read(BASE + 32'h4, d);
        chk("swrst_keep_cpb", d, {16'b0, m_cpb});
        wb_read(BASE + 32'hC, d);
        chk("swrst_keep_scratch", d, 32'hDEAD_BEEF);

        // Debounce: short glitch is rejected, held level accepted
        seen = 1'b0;
        @(negedge clk);
        pad = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (prog_o !== 1'b0) seen = 1'b1;
        end
        pad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (prog_o !== 1'b0) seen = 1'b1;
        end
        chk("glitch_prog", {31'b0, seen}, 32'h0);
        pad = 1'b1;
        first = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (prog_o === 1'b1) begin
                first = k;
                break;
            end
        end
        chk("deb_latency", first, 2 + DEBOUNCE + 1);
        m_deb = 1'b1;
        wb_read(BASE + 32'h8, d);
        chk("status_110", d, 32'h6);

        // Override in both directions
        wb_write(BASE, 32'h2, 4'hF);
        wb_write(BASE, 32'h0, 4'hF);
        pad = 1'b0;
        repeat (15) @(negedge clk);
        m_deb = 1'b0;
        chk("pad_low_prog", {31'b0, prog_o}, 32'h0);
        wb_write(BASE, 32'h6, 4'hF);
        wb_write(BASE, 32'h0, 4'hF);

        // Outside the window
        seen = 1'b0;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h100;
        repeat (10) begin
            @(negedge clk);
            if (ack !== 1'b0 || rdat !== 32'h0) seen = 1'b1;
        end
        stb = 1'b0; cyc = 1'b0;
        chk("outside_no_ack", {31'b0, seen}, 32'h0);

        // Unmapped offset in window
        wb_read(BASE + 32'h20, d);
        chk("unmapped_zero", d, 32'h0);

        // Continuous strobe alternates ack
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h4;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("cont_ack_%0d", c), {31'b0, ack}, {31'b0, 1'(c % 2)});
            if (c % 2 == 1) chk($sformatf("cont_dat_%0d", c), rdat, {16'b0, m_cpb});
        end
        stb = 1'b0; cyc = 1'b0;

        // Reset during an ack cycle
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'hC;
        @(negedge clk);
        chk("midrst_ack_before", {31'b0, ack}, 32'h1);
        rst = 1'b1;
        #1;
        chk("midrst_ack", {31'b0, ack}, 32'h0);
        chk("midrst_dat", rdat, 32'h0);
        chk("midrst_cpb", {16'b0, cpb}, 32'd868);
        chk("midrst_soc", {31'b0, soc_rst_ni}, 32'h0);
        chk("midrst_prog", {31'b0, prog_o}, 32'h0);
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
